// File: rtl/sram_axi_mport_bridge.sv
// NPORT SRAM-like ports arbitrated round-robin onto one AXI3 master, AXI ID = port index.
// Define BRIDGE_RAW_ADDR_CMP_EN to block reads only against an in-flight write to the same word.
module sram_axi_mport_bridge #(
    parameter int NPORT      = 2,
    parameter int MAX_RD_OUT = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [NPORT-1:0]      req,
    input  logic [NPORT-1:0]      wr,
    input  logic [2*NPORT-1:0]    size,
    input  logic [32*NPORT-1:0]   addr,
    input  logic [4*NPORT-1:0]    wstrb,
    input  logic [32*NPORT-1:0]   wdata,
    output logic [NPORT-1:0]      addr_ok,
    output logic [NPORT-1:0]      data_ok,
    output logic [32*NPORT-1:0]   rdata,
    output logic [3:0]            arid,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [1:0]            arlock,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [3:0]            rid,
    input  logic [31:0]           rdata_axi,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [3:0]            awid,
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [1:0]            awlock,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [3:0]            wid,
    output logic [31:0]           wdata_axi,
    output logic [3:0]            wstrb_axi,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [3:0]            bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CNT_W = 3;

    logic [NPORT-1:0][31:0] addr_v, wdata_v;
    logic [NPORT-1:0][1:0]  size_v;
    logic [NPORT-1:0][3:0]  wstrb_v;
    assign addr_v  = addr;
    assign wdata_v = wdata;
    assign size_v  = size;
    assign wstrb_v = wstrb;

    logic [PTR_W-1:0]            ptr_q, ptr_d, gnt_idx;
    logic [PTR_W:0]              rr_sum;
    logic                        gnt_vld, gnt_wr, ar_free;
    logic [NPORT-1:0]            elig, raw_ok, rd_inc, rd_dec;
    logic [NPORT-1:0][CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic                        wr_busy_q, arvalid_q, awvalid_q, wvalid_q;
    logic [3:0]                  arid_q, awid_q, wstrb_q;
    logic [31:0]                 araddr_q, awaddr_q, wdata_q;
    logic [2:0]                  arsize_q, awsize_q;
    logic                        unused_resp;

    assign unused_resp = ^{rresp, rlast, bresp};
    assign ar_free     = !arvalid_q || arready;

    always_comb begin
        raw_ok = '0;
        elig   = '0;
        for (int p = 0; p < NPORT; p++) begin
`ifdef BRIDGE_RAW_ADDR_CMP_EN
            raw_ok[p] = !(wr_busy_q && (addr_v[p][31:2] == awaddr_q[31:2]));
`else
            raw_ok[p] = !wr_busy_q;
`endif
            // a write waits for the port's own reads to drain so it cannot overtake them
            if (wr[p]) elig[p] = req[p] && !wr_busy_q && (rd_cnt_q[p] == '0);
            else       elig[p] = req[p] && (rd_cnt_q[p] < CNT_W'(MAX_RD_OUT)) && ar_free && raw_ok[p];
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int i = 0; i < NPORT; i++) begin
            rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (rr_sum >= (PTR_W+1)'(NPORT)) rr_sum = rr_sum - (PTR_W+1)'(NPORT);
            if (!gnt_vld && elig[rr_sum[PTR_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sum[PTR_W-1:0];
            end
        end
    end

    assign gnt_wr  = wr[gnt_idx];
    assign addr_ok = gnt_vld ? (NPORT'(1) << gnt_idx) : '0;
    assign ptr_d   = !gnt_vld ? ptr_q :
                     (gnt_idx == PTR_W'(NPORT-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        rd_inc   = addr_ok & ~wr;
        rd_dec   = '0;
        data_ok  = '0;
        rd_cnt_d = rd_cnt_q;
        for (int p = 0; p < NPORT; p++) begin
            rd_dec[p]  = rvalid && (rid == 4'(p));
            data_ok[p] = rd_dec[p] || (bvalid && (bid == 4'(p)));
            if (rd_inc[p] && !rd_dec[p])
                rd_cnt_d[p] = rd_cnt_q[p] + 1'b1;
            else if (rd_dec[p] && !rd_inc[p] && (rd_cnt_q[p] != '0))
                rd_cnt_d[p] = rd_cnt_q[p] - 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q     <= '0;
            rd_cnt_q  <= '0;
            wr_busy_q <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rd_cnt_q <= rd_cnt_d;
            if (arready) arvalid_q <= 1'b0;
            if (awready) awvalid_q <= 1'b0;
            if (wready)  wvalid_q  <= 1'b0;
            if (bvalid)  wr_busy_q <= 1'b0;
            // a new grant overrides the clear, so an AR released this cycle is refilled without a bubble
            if (gnt_vld && !gnt_wr) begin
                arvalid_q <= 1'b1;
                arid_q    <= 4'(gnt_idx);
                araddr_q  <= addr_v[gnt_idx];
                arsize_q  <= {1'b0, size_v[gnt_idx]};
            end
            if (gnt_vld && gnt_wr) begin
                wr_busy_q <= 1'b1;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                awid_q    <= 4'(gnt_idx);
                awaddr_q  <= addr_v[gnt_idx];
                awsize_q  <= {1'b0, size_v[gnt_idx]};
                wdata_q   <= wdata_v[gnt_idx];
                wstrb_q   <= wstrb_v[gnt_idx];
            end
        end
    end

    assign rdata     = {NPORT{rdata_axi}};
    assign arid      = arid_q;
    assign araddr    = araddr_q;
    assign arsize    = arsize_q;
    assign arvalid   = arvalid_q;
    assign arlen     = 8'd0;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign rready    = 1'b1;
    assign awid      = awid_q;
    assign awaddr    = awaddr_q;
    assign awsize    = awsize_q;
    assign awvalid   = awvalid_q;
    assign awlen     = 8'd0;
    assign awburst   = 2'b01;
    assign awlock    = 2'b00;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;
    assign wid       = awid_q;
    assign wdata_axi = wdata_q;
    assign wstrb_axi = wstrb_q;
    assign wlast     = 1'b1;
    assign wvalid    = wvalid_q;
    assign bready    = 1'b1;
endmodule

// File: tb/tb_sram_axi_mport_bridge.sv
// Randomized bench: transaction-level model of grants/ordering plus a reactive AXI slave.
module tb_sram_axi_mport_bridge;
    localparam int NP = 2;
    localparam int MR = 2;

    logic aclk = 1'b0, aresetn;
    logic [NP-1:0] req, wr, addr_ok, data_ok;
    logic [2*NP-1:0] size;
    logic [32*NP-1:0] addr, wdata, rdata;
    logic [4*NP-1:0] wstrb;
    logic [3:0] arid, awid, wid, rid, bid, arcache, awcache, wstrb_axi;
    logic [31:0] araddr, awaddr, rdata_axi, wdata_axi;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize, arprot, awprot;
    logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
    logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic wlast, wvalid, wready, bvalid, bready;

    sram_axi_mport_bridge #(.NPORT(NP), .MAX_RD_OUT(MR)) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_axi(wdata_axi), .wstrb_axi(wstrb_axi), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct { int id; logic [31:0] d; int due; } rsp_t;
    typedef struct { int id; logic [31:0] d; } exp_t;
    rsp_t sq[$];
    exp_t expq[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int ptr, b_due, r_idx;
    int rd_out [NP];
    bit wr_busy, ar_v, aw_v, w_v, s_aw, s_w, force_rd;
    logic [3:0] ar_id, wr_id, wr_stb, s_bid;
    logic [31:0] ar_addr, wr_addr, wr_dat;
    logic [2:0] ar_size, wr_size;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hdeadbeef;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0010;
            1: return 32'h0000_0020;
            2: return 32'h1c00_0000;
            3: return 32'h0000_0014;
            default: return $urandom;
        endcase
    endfunction

    function automatic bit raw_ok(input int p);
`ifdef BRIDGE_RAW_ADDR_CMP_EN
        return !(wr_busy && (addr[32*p+2 +: 30] == wr_addr[31:2]));
`else
        return !wr_busy;
`endif
    endfunction

    // The winner is the first requesting, eligible port at or after the pointer.
    function automatic int model_grant();
        for (int i = 0; i < NP; i++) begin
            int p = (ptr + i) % NP;
            bit ok;
            if (req[p]) begin
                if (wr[p]) ok = !wr_busy && rd_out[p] == 0;
                else       ok = rd_out[p] < MR && (!ar_v || arready) && raw_ok(p);
                if (ok) return p;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr = 0; wr_busy = 0; ar_v = 0; aw_v = 0; w_v = 0;
        s_aw = 0; s_w = 0; b_due = -1; r_idx = -1;
        for (int p = 0; p < NP; p++) rd_out[p] = 0;
        sq.delete();
        expq.delete();
    endtask

    task automatic drive();
        bit pa, pq;
        pa = cyc < 800;
        pq = cyc >= 2450 && cyc < 2500;
        for (int p = 0; p < NP; p++) begin
            if (pa || pq || force_rd) begin req[p] = 1'b1; wr[p] = 1'b0; end
            else begin
                req[p] = $urandom_range(0, 9) < 6;
                wr[p]  = $urandom_range(0, 9) < 3;
            end
            size[2*p +: 2]   = 2'($urandom_range(0, 2));
            addr[32*p +: 32] = pick_addr();
            wstrb[4*p +: 4]  = 4'($urandom);
            wdata[32*p +: 32] = $urandom;
        end
        arready = (pa || pq || force_rd) ? 1'b1 : ($urandom_range(0, 9) < 7);
        awready = pa ? 1'b1 : ($urandom_range(0, 9) < 5);
        wready  = pa ? 1'b1 : ($urandom_range(0, 9) < 5);
        bvalid  = s_aw && s_w && b_due >= 0 && cyc >= b_due && ($urandom_range(0, 9) < 8);
        bid     = bvalid ? s_bid : 4'($urandom);
        bresp   = 2'($urandom);
        r_idx = -1;
        if (!pq && $urandom_range(0, 9) < 7) begin
            int cand[$];
            bit seen [16];
            foreach (seen[k]) seen[k] = 0;
            // per-ID order is kept; different IDs may return out of order
            for (int k = 0; k < sq.size(); k++) begin
                int id = sq[k].id & 15;
                if (!seen[id]) begin
                    seen[id] = 1;
                    if (sq[k].due <= cyc && !(bvalid && int'(bid) == id)) cand.push_back(k);
                end
            end
            if (cand.size() > 0) r_idx = cand[$urandom_range(0, cand.size() - 1)];
        end
        rvalid    = r_idx >= 0;
        rid       = rvalid ? 4'(sq[r_idx].id) : 4'($urandom);
        rdata_axi = rvalid ? sq[r_idx].d : $urandom;
        rresp     = 2'($urandom);
        rlast     = 1'b1;
    endtask

    task automatic check_update();
        int g, k;
        logic [NP-1:0] eaok, edok;
        exp_t e;
        rsp_t r;
        g = model_grant();
        eaok = (g >= 0) ? NP'(1 << g) : '0;
        if (force_rd) chk("post_rst_grant", 64'(addr_ok), 64'(2'b01));
        chk("addr_ok", 64'(addr_ok), 64'(eaok));
        for (int p = 0; p < NP; p++)
            edok[p] = (rvalid && int'(rid) == p) || (bvalid && int'(bid) == p);
        chk("data_ok", 64'(data_ok), 64'(edok));
        chk("arvalid", 64'(arvalid), 64'(ar_v));
        if (ar_v) chk("ar_fields", 64'({arid, araddr, arsize}), 64'({ar_id, ar_addr, ar_size}));
        chk("awvalid", 64'(awvalid), 64'(aw_v));
        if (aw_v) chk("aw_fields", 64'({awid, awaddr, awsize}), 64'({wr_id, wr_addr, wr_size}));
        chk("wvalid", 64'(wvalid), 64'(w_v));
        if (w_v) chk("w_fields", 64'({wid, wdata_axi, wstrb_axi, wlast}), 64'({wr_id, wr_dat, wr_stb, 1'b1}));
        chk("axi_const",
            64'({rready, bready, arlen, arburst, arlock, arcache, arprot, awlen, awburst, awlock, awcache, awprot}),
            64'({2'b11, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
        if (rvalid) begin
            k = -1;
            for (int i = 0; i < expq.size(); i++)
                if (k < 0 && expq[i].id == int'(rid)) k = i;
            chk("r_sb_hit", 64'(k >= 0), 64'(1));
            if (k >= 0) begin
                chk("rdata", 64'(rdata[32*int'(rid[0]) +: 32]), 64'(expq[k].d));
                expq.delete(k);
            end
        end
        // model state advances as at the clock edge
        if (ar_v && arready) ar_v = 0;
        if (aw_v && awready) aw_v = 0;
        if (w_v && wready) w_v = 0;
        if (bvalid) wr_busy = 0;
        if (rvalid && int'(rid) < NP && rd_out[rid] > 0) rd_out[rid]--;
        if (g >= 0) begin
            ptr = (g + 1) % NP;
            if (wr[g]) begin
                wr_busy = 1; aw_v = 1; w_v = 1;
                wr_id = 4'(g); wr_addr = addr[32*g +: 32]; wr_size = {1'b0, size[2*g +: 2]};
                wr_dat = wdata[32*g +: 32]; wr_stb = wstrb[4*g +: 4];
            end else begin
                rd_out[g]++; ar_v = 1;
                ar_id = 4'(g); ar_addr = addr[32*g +: 32]; ar_size = {1'b0, size[2*g +: 2]};
                e.id = g; e.d = fdat(ar_addr);
                expq.push_back(e);
            end
        end
        // slave reacts to what the DUT actually drives
        if (rvalid) sq.delete(r_idx);
        if (bvalid) begin s_aw = 0; s_w = 0; b_due = -1; end
        if (arvalid && arready) begin
            r.id = int'(arid); r.d = fdat(araddr); r.due = cyc + 1 + $urandom_range(0, 3);
            sq.push_back(r);
        end
        if (awvalid && awready) begin s_aw = 1; s_bid = awid; end
        if (wvalid && wready) s_w = 1;
        if (s_aw && s_w && b_due < 0) b_due = cyc + 1 + $urandom_range(0, 2);
    endtask

    task automatic reset_checks(input string tag);
        req = '0; rvalid = 1'b0; bvalid = 1'b0;
        #1;
        chk({tag, "_valids"}, 64'({arvalid, awvalid, wvalid}), 64'(0));
        chk({tag, "_oks"}, 64'({addr_ok, data_ok}), 64'(0));
        chk({tag, "_regs"}, 64'({arid, araddr[27:0], awid, awaddr[27:0]}), 64'(0));
        chk({tag, "_ready"}, 64'({rready, bready}), 64'(2'b11));
    endtask

    initial begin
        req = '0; wr = '0; size = '0; addr = '0; wstrb = '0; wdata = '0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; rid = '0; rdata_axi = '0;
        rresp = '0; rlast = 0; bvalid = 0; bid = '0; bresp = '0; force_rd = 0;
        aresetn = 1'b0;
        model_reset();
        repeat (3) @(posedge aclk);
        reset_checks("rst");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2500) begin
                aresetn = 1'b0;
                reset_checks("async_rst");
                model_reset();
                repeat (2) @(posedge aclk);
                #1 aresetn = 1'b1;
                force_rd = 1;
            end
            drive();
            @(negedge aclk);
            check_update();
            force_rd = 0;
            @(posedge aclk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
